riscv_decode_stage: RTL and testbench

Pipelined decode stage that sits directly upstream of the execution ALU: accepts fetched RV32 instructions over a valid/ready handshake, decodes them, reads operands from the register file and emits a registered bundle `exec_fun`/`data1`/`data2` plus writeback and branch side-information. A 2-entry skid buffer keeps `in_ready` registered and absorbs one cycle of downstream back-pressure. Supported subset: ADD, SLT, ADDI, SLTI, LUI, LW, SW, BEQ. Everything else is flagged illegal.

---
 rtl/riscv_constants.sv | 50 +++++
 rtl/riscv_decoder.sv | 118 +++++++++++
 rtl/riscv_decode_stage.sv | 124 ++++++++++++
 tb/tb_riscv_decode_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// rtl/riscv_constants.sv - shared RV32 decode constants, ALU op enum and decode bundle
package riscv_constants;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALU_X   = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SLT = 2'd2
  } exec_fun_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;

  typedef struct packed {
    exec_fun_t         exec_fun;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_wen;
    logic              is_branch;
    logic [XLEN-1:0]   br_target;
    logic              mem_rd;
    logic              mem_wr;
    logic [XLEN-1:0]   store_data;
    logic              illegal;
  } decode_bundle_t;

  // Idle payload: everything zero, ALU op explicitly "don't care".
  function automatic decode_bundle_t empty_bundle();
    decode_bundle_t b;
    b          = '0;
    b.exec_fun = ALU_X;
    return b;
  endfunction

endpackage

// File: rtl/riscv_decoder.sv
// rtl/riscv_decoder.sv - combinational RV32 subset decoder producing a decode bundle
module riscv_decoder
  import riscv_constants::*;
(
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output decode_bundle_t  bundle
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] u_imm;
  logic            writes_rd;
  decode_bundle_t  b;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign rs1_idx = inst[19:15];
  assign rs2_idx = inst[24:20];
  assign rd_idx  = inst[11:7];

  // x0 is hardwired to zero whatever the register file returns.
  assign op1 = (rs1_idx == 5'd0) ? '0 : rs1_data;
  assign op2 = (rs2_idx == 5'd0) ? '0 : rs2_data;

  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};

  always_comb begin
    b         = empty_bundle();
    b.illegal = 1'b1;
    writes_rd = 1'b0;

    case (opcode)
      OP_R: begin
        if (funct7 == F7_ZERO && (funct3 == F3_ADD || funct3 == F3_SLT)) begin
          b.illegal  = 1'b0;
          b.exec_fun = (funct3 == F3_SLT) ? ALU_SLT : ALU_ADD;
          b.data1    = op1;
          b.data2    = op2;
          writes_rd  = 1'b1;
        end
      end
      OP_I: begin
        if (funct3 == F3_ADD || funct3 == F3_SLT) begin
          b.illegal  = 1'b0;
          b.exec_fun = (funct3 == F3_SLT) ? ALU_SLT : ALU_ADD;
          b.data1    = op1;
          b.data2    = i_imm;
          writes_rd  = 1'b1;
        end
      end
      OP_LUI: begin
        b.illegal  = 1'b0;
        b.exec_fun = ALU_ADD;
        b.data1    = '0;
        b.data2    = u_imm;
        writes_rd  = 1'b1;
      end
      OP_LW: begin
        if (funct3 == F3_LW) begin
          b.illegal  = 1'b0;
          b.exec_fun = ALU_ADD;
          b.data1    = op1;
          b.data2    = i_imm;
          b.mem_rd   = 1'b1;
          writes_rd  = 1'b1;
        end
      end
      OP_SW: begin
        if (funct3 == F3_SW) begin
          b.illegal    = 1'b0;
          b.exec_fun   = ALU_ADD;
          b.data1      = op1;
          b.data2      = s_imm;
          b.mem_wr     = 1'b1;
          b.store_data = op2;
        end
      end
      OP_BR: begin
        if (funct3 == F3_BEQ) begin
          b.illegal   = 1'b0;
          b.exec_fun  = ALU_X;
          b.data1     = op1;
          b.data2     = op2;
          b.is_branch = 1'b1;
          b.br_target = pc + b_imm;
        end
      end
      default: begin
        b.illegal = 1'b1;
      end
    endcase

    // Non-writing formats reuse inst[11:7] as immediate bits, so rd stays 0 for them.
    if (writes_rd) begin
      b.rd_addr = rd_idx;
      b.rd_wen  = (rd_idx != 5'd0);
    end
  end

  assign bundle = b;

endmodule

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - registered decode stage with 2-entry skid buffer
module riscv_decode_stage
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH    = XLEN,
  parameter int REG_ADDR_WIDTH = REG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_inst,
  input  logic [WORD_LENGTH-1:0]    in_pc,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [WORD_LENGTH-1:0]    rs1_data,
  input  logic [WORD_LENGTH-1:0]    rs2_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output exec_fun_t                 out_exec_fun,
  output logic [WORD_LENGTH-1:0]    out_data1,
  output logic [WORD_LENGTH-1:0]    out_data2,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_rd_wen,
  output logic                      out_is_branch,
  output logic [WORD_LENGTH-1:0]    out_br_target,
  output logic                      out_mem_rd,
  output logic                      out_mem_wr,
  output logic [WORD_LENGTH-1:0]    out_store_data,
  output logic                      out_illegal
);

  decode_bundle_t dec;
  decode_bundle_t main_d, main_q;
  decode_bundle_t skid_d, skid_q;
  logic           main_valid_d, main_valid_q;
  logic           skid_valid_d, skid_valid_q;
  logic           accept;

  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  riscv_decoder u_decoder (
    .inst     (in_inst),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec)
  );

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (accept) begin
            main_d       = dec;
            main_valid_d = 1'b1;
          end
        end
        2'b10: begin
          if (accept && out_ready) begin
            main_d = dec;
          end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
          end else if (out_ready) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: begin
          if (out_ready) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Skid without main is unreachable; recover to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= empty_bundle();
      skid_q       <= empty_bundle();
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_exec_fun   = main_q.exec_fun;
  assign out_data1      = main_q.data1;
  assign out_data2      = main_q.data2;
  assign out_rd_addr    = main_q.rd_addr;
  assign out_rd_wen     = main_q.rd_wen;
  assign out_is_branch  = main_q.is_branch;
  assign out_br_target  = main_q.br_target;
  assign out_mem_rd     = main_q.mem_rd;
  assign out_mem_wr     = main_q.mem_wr;
  assign out_store_data = main_q.store_data;
  assign out_illegal    = main_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - directed scoreboard bench for riscv_decode_stage
module tb_riscv_decode_stage;
  import riscv_constants::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, out_rd_addr;
  exec_fun_t   out_exec_fun;
  logic [31:0] out_data1, out_data2, out_br_target, out_store_data;
  logic        out_rd_wen, out_is_branch, out_mem_rd, out_mem_wr, out_illegal;

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  riscv_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_exec_fun(out_exec_fun),
    .out_data1(out_data1), .out_data2(out_data2), .out_rd_addr(out_rd_addr),
    .out_rd_wen(out_rd_wen), .out_is_branch(out_is_branch), .out_br_target(out_br_target),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    exec_fun_t   fun;
    logic [31:0] d1, d2;
    logic [4:0]  rd;
    logic        wen, br;
    logic [31:0] tgt;
    logic        mrd, mwr;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   beat     = 0;

  function automatic exp_t mk(exec_fun_t fun, logic [31:0] d1, logic [31:0] d2, logic [4:0] rd,
                              logic wen, logic br, logic [31:0] tgt, logic mrd, logic mwr,
                              logic [31:0] sd, logic ill);
    exp_t e;
    e.fun = fun; e.d1 = d1; e.d2 = d2; e.rd = rd; e.wen = wen; e.br = br;
    e.tgt = tgt; e.mrd = mrd; e.mwr = mwr; e.sd = sd; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Beats transfer at the next rising edge; compare them at the falling edge before it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed beat data1=0x%0h expected no beat", out_data1);
      end
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        chk($sformatf("b%0d_exec_fun", beat), 32'(out_exec_fun), 32'(cur.fun));
        chk($sformatf("b%0d_data1", beat), out_data1, cur.d1);
        chk($sformatf("b%0d_data2", beat), out_data2, cur.d2);
        chk($sformatf("b%0d_rd_addr", beat), 32'(out_rd_addr), 32'(cur.rd));
        chk($sformatf("b%0d_rd_wen", beat), 32'(out_rd_wen), 32'(cur.wen));
        chk($sformatf("b%0d_is_branch", beat), 32'(out_is_branch), 32'(cur.br));
        chk($sformatf("b%0d_br_target", beat), out_br_target, cur.tgt);
        chk($sformatf("b%0d_mem_rd", beat), 32'(out_mem_rd), 32'(cur.mrd));
        chk($sformatf("b%0d_mem_wr", beat), 32'(out_mem_wr), 32'(cur.mwr));
        chk($sformatf("b%0d_store_data", beat), out_store_data, cur.sd);
        chk($sformatf("b%0d_illegal", beat), 32'(out_illegal), 32'(cur.ill));
      end
      beat++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e, input bit push);
    int budget;
    budget   = 50;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      chk("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      if (push) sb.push_back(e);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 50;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_ADDI0 = 32'h00500013;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SLT   = 32'h0020A1B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_LW    = 32'h0040A203;
  localparam logic [31:0] I_SW    = 32'hFE20AE23;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

  exp_t e_addi, e_add, e_slt, e_lui, e_ill, e_none;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA5000000 | 32'(i);
    rf[0] = 32'hDEADBEEF;
    rf[1] = 32'd7;
    rf[2] = 32'd9;

    e_addi = mk(ALU_ADD, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    e_add  = mk(ALU_ADD, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    e_slt  = mk(ALU_SLT, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    e_lui  = mk(ALU_ADD, 32'd0, 32'h12345000, 5'd5, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    e_ill  = mk(ALU_X, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    e_none = e_ill;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 32'd0;
    tick();
    in_valid = 1'b1;
    in_inst  = I_ADDI;
    tick();
    in_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_exec_fun", 32'(out_exec_fun), 32'(ALU_X));
    chk("rst_data1", out_data1, 32'd0);
    chk("rst_data2", out_data2, 32'd0);
    chk("rst_br_target", out_br_target, 32'd0);
    chk("rst_rd_wen", 32'(out_rd_wen), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    in_inst = I_SW;
    #1;
    chk("rs1_addr", 32'(rs1_addr), 32'd1);
    chk("rs2_addr", 32'(rs2_addr), 32'd2);

    out_ready = 1'b1;
    send(I_ADDI, 32'h0, e_addi, 1'b1);
    chk("addi_latency_valid", 32'(out_valid), 32'd1);
    drain();

    send(I_ADD, 32'h4, e_add, 1'b1);
    send(I_SLT, 32'h8, e_slt, 1'b1);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    drain();

    send(I_BEQ, 32'h100, mk(ALU_X, 32'd7, 32'd9, 5'd0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 32'd0, 1'b0), 1'b1);
    send(I_BEQ, 32'hFFFFFFFC, mk(ALU_X, 32'd7, 32'd9, 5'd0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 1'b0), 1'b1);
    drain();

    send(I_LW, 32'h0, mk(ALU_ADD, 32'd7, 32'd4, 5'd4, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0), 1'b1);
    send(I_SW, 32'h0, mk(ALU_ADD, 32'd7, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd9, 1'b0), 1'b1);
    send(I_ADDI0, 32'h0, mk(ALU_ADD, 32'd0, 32'd5, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0), 1'b1);
    send(I_SUB, 32'h0, e_ill, 1'b1);
    send(I_BAD, 32'h0, e_ill, 1'b1);
    drain();

    out_ready = 1'b0;
    send(I_LUI, 32'h0, e_lui, 1'b1);
    send(I_ADDI, 32'h4, e_addi, 1'b1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_data2", out_data2, 32'h12345000);
    tick();
    tick();
    chk("bp_hold_data2", out_data2, 32'h12345000);
    chk("bp_hold_rd", 32'(out_rd_addr), 32'd5);
    out_ready = 1'b1;
    drain();
    chk("bp_after_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b0;
    send(I_ADD, 32'h0, e_none, 1'b0);
    send(I_SLT, 32'h4, e_none, 1'b0);
    chk("fl_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_inst  = I_ADDI;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_no_beats", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    send(I_ADD, 32'h0, e_none, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_data1", out_data1, 32'd0);
    chk("rstmid_exec_fun", 32'(out_exec_fun), 32'(ALU_X));
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("final_queue", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
